// File: rtl/axi_wr_arbiter.sv
// axi_wr_arbiter
//   Two-requester round-robin arbiter in front of a single-beat AXI write
//   master. The winner's address/data/strobes are captured at grant time and
//   presented on AW/W until handshake. The B response (or a timeout) ends the
//   transaction with a one-cycle ack/err pulse to the owner.
//
// Ports
//   clk_domain_a, rst_n          clock, async active-low reset
//   req*/addr*/data*/strb*       requester 0/1 write request and payload
//   ack*/err*                    one-cycle completion pulse, error qualifier
//   m_aw*, m_w*, m_b*            AXI write address/data/response channels
//   grant, busy                  current owner index, transaction in flight
module axi_wr_arbiter #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                      clk_domain_a,
    input  logic                      rst_n,
    input  logic                      req0,
    input  logic                      req1,
    input  logic [ADDR_WIDTH-1:0]     addr0,
    input  logic [ADDR_WIDTH-1:0]     addr1,
    input  logic [DATA_WIDTH-1:0]     data0,
    input  logic [DATA_WIDTH-1:0]     data1,
    input  logic [DATA_WIDTH/8-1:0]   strb0,
    input  logic [DATA_WIDTH/8-1:0]   strb1,
    output logic                      ack0,
    output logic                      ack1,
    output logic                      err0,
    output logic                      err1,
    output logic                      m_awvalid,
    output logic [ADDR_WIDTH-1:0]     m_awaddr,
    input  logic                      m_awready,
    output logic                      m_wvalid,
    output logic [DATA_WIDTH-1:0]     m_wdata,
    output logic [DATA_WIDTH/8-1:0]   m_wstrb,
    input  logic                      m_wready,
    input  logic                      m_bvalid,
    input  logic [1:0]                m_bresp,
    output logic                      m_bready,
    output logic                      grant,
    output logic                      busy
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_XFER, S_RESP, S_DONE} state_t;

    state_t              state_q, state_d;
    logic                last_grant_q, last_grant_d;
    logic                grant_q, grant_d;
    logic                busy_q, busy_d;
    logic                awvalid_q, awvalid_d;
    logic                wvalid_q, wvalid_d;
    logic                bready_q, bready_d;
    logic                ack0_q, ack0_d, ack1_q, ack1_d;
    logic                err0_q, err0_d, err1_q, err1_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [STRB_W-1:0]   strb_q, strb_d;
    logic [15:0]         cnt_q, cnt_d;

    logic                win;
    logic                to_done;
    logic                done_err;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        busy_d       = busy_q;
        awvalid_d    = awvalid_q;
        wvalid_d     = wvalid_q;
        bready_d     = bready_q;
        addr_d       = addr_q;
        data_d       = data_q;
        strb_d       = strb_q;
        cnt_d        = cnt_q;
        ack0_d       = 1'b0;
        ack1_d       = 1'b0;
        err0_d       = 1'b0;
        err1_d       = 1'b0;
        win          = 1'b0;
        to_done      = 1'b0;
        done_err     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req0 || req1) begin
                    // On a tie the requester that did not win last time goes.
                    win          = (req0 && req1) ? ~last_grant_q : req1;
                    grant_d      = win;
                    last_grant_d = win;
                    addr_d       = win ? addr1 : addr0;
                    data_d       = win ? data1 : data0;
                    strb_d       = win ? strb1 : strb0;
                    awvalid_d    = 1'b1;
                    wvalid_d     = 1'b1;
                    busy_d       = 1'b1;
                    cnt_d        = '0;
                    state_d      = S_XFER;
                end
            end
            S_XFER: begin
                cnt_d = cnt_q + 16'd1;
                if (cnt_q == CNT_LAST) begin
                    awvalid_d = 1'b0;
                    wvalid_d  = 1'b0;
                    to_done   = 1'b1;
                    done_err  = 1'b1;
                end else begin
                    // Each channel retires on its own handshake; a channel
                    // already retired counts as complete.
                    awvalid_d = awvalid_q & ~m_awready;
                    wvalid_d  = wvalid_q & ~m_wready;
                    if ((!awvalid_q || m_awready) && (!wvalid_q || m_wready)) begin
                        bready_d = 1'b1;
                        state_d  = S_RESP;
                    end
                end
            end
            S_RESP: begin
                cnt_d = cnt_q + 16'd1;
                // Response beats timeout when both land in the same cycle.
                if (m_bvalid) begin
                    bready_d = 1'b0;
                    to_done  = 1'b1;
                    done_err = (m_bresp != 2'b00);
                end else if (cnt_q == CNT_LAST) begin
                    bready_d = 1'b0;
                    to_done  = 1'b1;
                    done_err = 1'b1;
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (to_done) begin
            state_d = S_DONE;
            ack0_d  = ~grant_q;
            ack1_d  = grant_q;
            err0_d  = ~grant_q & done_err;
            err1_d  = grant_q & done_err;
        end
    end

    always_ff @(posedge clk_domain_a or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            busy_q       <= 1'b0;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            bready_q     <= 1'b0;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            err0_q       <= 1'b0;
            err1_q       <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
            strb_q       <= '0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            busy_q       <= busy_d;
            awvalid_q    <= awvalid_d;
            wvalid_q     <= wvalid_d;
            bready_q     <= bready_d;
            ack0_q       <= ack0_d;
            ack1_q       <= ack1_d;
            err0_q       <= err0_d;
            err1_q       <= err1_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            strb_q       <= strb_d;
            cnt_q        <= cnt_d;
        end
    end

    assign ack0      = ack0_q;
    assign ack1      = ack1_q;
    assign err0      = err0_q;
    assign err1      = err1_q;
    assign m_awvalid = awvalid_q;
    assign m_awaddr  = addr_q;
    assign m_wvalid  = wvalid_q;
    assign m_wdata   = data_q;
    assign m_wstrb   = strb_q;
    assign m_bready  = bready_q;
    assign grant     = grant_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_axi_wr_arbiter.sv
module tb_axi_wr_arbiter;
    localparam int DW = 32;
    localparam int AW = 16;
    localparam int SW = DW / 8;
    localparam int TO = 8;

    logic          clk_domain_a = 1'b0;
    logic          rst_n = 1'b0;
    logic          req [2];
    logic [AW-1:0] pa [2];
    logic [DW-1:0] pd [2];
    logic [SW-1:0] ps [2];
    logic          ack0, ack1, err0, err1;
    logic          m_awvalid, m_awready, m_wvalid, m_wready;
    logic          m_bvalid, m_bready;
    logic [1:0]    m_bresp;
    logic [AW-1:0] m_awaddr;
    logic [DW-1:0] m_wdata;
    logic [SW-1:0] m_wstrb;
    logic          grant, busy;

    int checks = 0;
    int errors = 0;
    bit lg_m;   // reference model: requester granted last

    axi_wr_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
        .clk_domain_a(clk_domain_a), .rst_n(rst_n),
        .req0(req[0]), .req1(req[1]),
        .addr0(pa[0]), .addr1(pa[1]),
        .data0(pd[0]), .data1(pd[1]),
        .strb0(ps[0]), .strb1(ps[1]),
        .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1),
        .m_awvalid(m_awvalid), .m_awaddr(m_awaddr), .m_awready(m_awready),
        .m_wvalid(m_wvalid), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wready(m_wready),
        .m_bvalid(m_bvalid), .m_bresp(m_bresp), .m_bready(m_bready),
        .grant(grant), .busy(busy)
    );

    always #5 clk_domain_a = ~clk_domain_a;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // {busy, awvalid, wvalid, bready, ack0, ack1, err0, err1}
    function automatic logic [7:0] ovec();
        return {busy, m_awvalid, m_wvalid, m_bready, ack0, ack1, err0, err1};
    endfunction

    task automatic raise(input int i);
        req[i] = 1'b1;
        pa[i]  = AW'($urandom);
        pd[i]  = $urandom;
        ps[i]  = SW'($urandom);
    endtask

    task automatic step();
        @(posedge clk_domain_a);
        @(negedge clk_domain_a);
    endtask

    // Entered at the negedge of the IDLE cycle (cycle 0) with a request up.
    // awd/wd: XFER cycles with ready low before ready rises; bd: RESP cycles
    // before bvalid (negative = never). Ends at the negedge of the next IDLE cycle.
    task automatic run_txn(input int awd, input int wd, input int bd, input logic [1:0] br);
        int w, m, cb, d;
        bit to, e;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        logic [SW-1:0] es;
        logic [7:0] ev;
        w  = (req[0] && req[1]) ? int'(!lg_m) : (req[1] ? 1 : 0);
        lg_m = w[0];
        ea = pa[w]; ed = pd[w]; es = ps[w];
        m  = (awd > wd) ? awd : wd;
        cb = 2 + m + bd;
        // Address/data must both finish before cycle TO, and the response
        // must arrive no later than cycle TO, otherwise the abort fires.
        to = (1 + m >= TO) || (bd < 0) || (cb > TO);
        d  = to ? TO + 1 : cb + 1;
        e  = to ? 1'b1 : (br != 2'b00);
        for (int c = 0; c <= d; c++) begin
            ev = {c >= 1,
                  c >= 1 && c <= 1 + awd && c < d,
                  c >= 1 && c <= 1 + wd && c < d,
                  c >= 2 + m && c < d,
                  c == d && w == 0,
                  c == d && w == 1,
                  c == d && w == 0 && e,
                  c == d && w == 1 && e};
            chk($sformatf("outs c%0d", c), ovec(), ev);
            if (c >= 1) begin
                chk("grant", grant, w);
                chk("awaddr", m_awaddr, ea);
                chk("wdata", m_wdata, ed);
                chk("wstrb", m_wstrb, es);
            end
            if (c == 1) begin
                // Payload changes after grant must not reach the bus.
                pa[w] = AW'($urandom); pd[w] = $urandom; ps[w] = SW'($urandom);
            end
            if (c == d) req[w] = 1'b0;
            m_awready = (c >= 1) && (c - 1 >= awd);
            m_wready  = (c >= 1) && (c - 1 >= wd);
            m_bvalid  = (bd >= 0) && (c == cb) && (c < d);
            m_bresp   = br;
            step();
        end
    endtask

    initial begin
        int awd, wd, bd;
        logic [1:0] br;
        req[0] = 0; req[1] = 0;
        pa[0] = 0; pa[1] = 0; pd[0] = 0; pd[1] = 0; ps[0] = 0; ps[1] = 0;
        m_awready = 0; m_wready = 0; m_bvalid = 0; m_bresp = 0;
        repeat (2) @(negedge clk_domain_a);
        chk("rst_outs", ovec(), 8'h00);
        chk("rst_grant", grant, 0);
        chk("rst_addr", m_awaddr, 0);
        rst_n = 1'b1;
        @(negedge clk_domain_a);
        lg_m = 1'b1;

        // Single requester, zero-wait slave.
        req[0] = 1; pa[0] = 16'h1234; pd[0] = 32'hDEADBEEF; ps[0] = 4'hF;
        run_txn(0, 0, 0, 2'b00);
        // AW accepted at once, W stalled three cycles.
        raise(0); run_txn(0, 3, 0, 2'b00);
        // SLVERR response to requester 1.
        raise(1); run_txn(0, 0, 0, 2'b10);
        // No response ever: timeout abort.
        raise(0); run_txn(0, 0, -1, 2'b00);
        // Both requesting back-to-back: grants alternate.
        for (int i = 0; i < 4; i++) begin
            if (!req[0]) raise(0);
            if (!req[1]) raise(1);
            run_txn(0, 0, 0, 2'b00);
        end

        for (int i = 0; i < 60; i++) begin
            if (!req[0] && $urandom_range(0, 1) == 1) raise(0);
            if (!req[1] && $urandom_range(0, 1) == 1) raise(1);
            if (!req[0] && !req[1]) begin
                chk("idle", ovec(), 8'h00);
                step();
                continue;
            end
            awd = ($urandom_range(0, 9) == 0) ? 7 : $urandom_range(0, 3);
            wd  = ($urandom_range(0, 9) == 0) ? 7 : $urandom_range(0, 3);
            bd  = ($urandom_range(0, 7) == 0) ? -1 : $urandom_range(0, 3);
            br  = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b00;
            run_txn(awd, wd, bd, br);
        end
        while (req[0] || req[1]) run_txn(0, 0, 0, 2'b00);
        chk("drained", ovec(), 8'h00);

        // Reset pulsed while waiting on the response.
        raise(0);
        m_awready = 1; m_wready = 1; m_bvalid = 0;
        step();
        step();
        chk("resp_bready", m_bready, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_outs", ovec(), 8'h00);
        chk("rst_mid_grant", grant, 0);
        chk("rst_mid_addr", m_awaddr, 0);
        req[0] = 0;
        step();
        rst_n = 1'b1;
        step();
        chk("post_rst_outs", ovec(), 8'h00);
        lg_m = 1'b1;
        raise(0); raise(1);
        run_txn(0, 0, 0, 2'b00);
        run_txn(0, 0, 0, 2'b00);
        chk("final_idle", ovec(), 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
